// File: rtl/alu_share_arb.sv
// Round-robin scheduler sharing one external 4-bit ALU between two requesters; optional ALU_SHARE_ARB_STATS_EN adds per-ID response counters.
// Latency: accept at edge N, captured result and rsp_valid visible after edge N+1; at most one op per 3 cycles.
// Backpressure: rsp_ready low holds RESP with a stable response; no request is accepted until the response handshake.
module alu_share_arb #(
  parameter int W     = 4,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [W-1:0]     alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_data,
`ifdef ALU_SHARE_ARB_STATS_EN
  input  logic             cnt_clr,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
`endif
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [SEL_W-1:0] SEL_ILLEGAL = {SEL_W{1'b1}};

  state_t           state_q, state_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic             err_q, err_d;
  logic             rsp_id_q, rsp_id_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  // ID granted last; resets to 1 so requester 0 wins the first contention
  logic             last_q, last_d;

  logic             grant0, grant1;
  logic [W-1:0]     win_a, win_b;
  logic [SEL_W-1:0] win_sel;

  // Round-robin winner selection among valid requesters
  always_comb begin
    grant0  = req0_valid & (~req1_valid | last_q);
    grant1  = req1_valid & (~req0_valid | ~last_q);
    win_a   = grant1 ? req1_a   : req0_a;
    win_b   = grant1 ? req1_b   : req0_b;
    win_sel = grant1 ? req1_sel : req0_sel;
  end

  // Next-state and datapath load logic for the IDLE/EXEC/RESP sequence
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    err_d      = err_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          req0_ready = grant0;
          req1_ready = grant1;
          alu_a_d    = win_a;
          alu_b_d    = win_b;
          rsp_id_d   = grant1;
          // An illegal op code runs as AND and is flagged in the response
          if (win_sel == SEL_ILLEGAL) begin
            alu_sel_d = '0;
            err_d     = 1'b1;
          end else begin
            alu_sel_d = win_sel;
            err_d     = 1'b0;
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_out;
        rsp_err_d  = err_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = rsp_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      err_q      <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      err_q      <= err_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      last_q     <= last_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

`ifdef ALU_SHARE_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;
  logic       rsp_hs;

  // Saturating per-ID handshake counters; clear wins over increment
  always_comb begin
    rsp_hs = rsp_valid & rsp_ready;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cnt_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (rsp_hs) begin
      if (!rsp_id_q && cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
      if (rsp_id_q && cnt1_q != 8'hFF)  cnt1_d = cnt1_q + 8'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
